// File: rtl/tug_field_ctrl_if.sv
// Playfield signal bundle between the game environment and tug_field_ctrl.
//   master : drives the raw keys and freeze; observes the field outputs
//   slave  : the playfield controller itself
// KeyL/KeyR  raw asynchronous player keys, active-high
// freeze     game over; presses still pulse but the field holds
// L/R        one-cycle conditioned press pulses
// leftLight/rightLight  lit position is at the left/right edge (PLAY only)
// lights     one-hot LED drive, all off during SCORE
// point/pointLeft       point pulse and scorer of the latest point
interface tug_field_ctrl_if #(
   parameter int NUM_LIGHTS = 9
);
   logic                  KeyL;
   logic                  KeyR;
   logic                  freeze;
   logic                  L;
   logic                  R;
   logic                  leftLight;
   logic                  rightLight;
   logic [NUM_LIGHTS-1:0] lights;
   logic                  point;
   logic                  pointLeft;

   modport master (
      output KeyL, KeyR, freeze,
      input  L, R, leftLight, rightLight, lights, point, pointLeft
   );

   modport slave (
      input  KeyL, KeyR, freeze,
      output L, R, leftLight, rightLight, lights, point, pointLeft
   );
endinterface

// File: rtl/tug_field_ctrl.sv
// Tug-of-war playfield. Synchronizes and edge-detects both player keys,
// moves a single lit position along NUM_LIGHTS LEDs and scores a point
// when a press pushes the light off either edge, then recentres.
// Ports:
//   Clock  system clock
//   Reset  asynchronous active-low reset
//   fld    tug_field_ctrl_if slave modport (keys, freeze, field outputs)
//
// state | meaning
// PLAY  | light at pos, presses move it one step
// SCORE | one cycle: point high, lights off, presses ignored
module tug_field_ctrl #(
   parameter int NUM_LIGHTS  = 9,
   parameter int SYNC_STAGES = 2
) (
   input  logic             Clock,
   input  logic             Reset,
   tug_field_ctrl_if.slave  fld
);

   localparam int              PW     = $clog2(NUM_LIGHTS);
   localparam logic [PW-1:0]   CENTER = PW'((NUM_LIGHTS - 1) / 2);
   localparam logic [PW-1:0]   LAST   = PW'(NUM_LIGHTS - 1);

   typedef enum logic {PLAY = 1'b0, SCORE = 1'b1} state_t;

   logic [SYNC_STAGES-1:0] sync_l;
   logic [SYNC_STAGES-1:0] sync_r;
   logic                   dly_l;
   logic                   dly_r;
   logic                   pulse_l;
   logic                   pulse_r;

   state_t                 state;
   logic [PW-1:0]          pos;
   logic                   point_q;
   logic                   point_left_q;

   // Synchronizer chain, delay flop and registered rising-edge pulse.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         sync_l  <= '0;
         sync_r  <= '0;
         dly_l   <= 1'b0;
         dly_r   <= 1'b0;
         pulse_l <= 1'b0;
         pulse_r <= 1'b0;
      end else begin
         sync_l  <= {sync_l[SYNC_STAGES-2:0], fld.KeyL};
         sync_r  <= {sync_r[SYNC_STAGES-2:0], fld.KeyR};
         dly_l   <= sync_l[SYNC_STAGES-1];
         dly_r   <= sync_r[SYNC_STAGES-1];
         pulse_l <= sync_l[SYNC_STAGES-1] & ~dly_l;
         pulse_r <= sync_r[SYNC_STAGES-1] & ~dly_r;
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state        <= PLAY;
         pos          <= CENTER;
         point_q      <= 1'b0;
         point_left_q <= 1'b0;
      end else begin
         point_q <= 1'b0;
         case (state)
            PLAY: begin
               if (pulse_l && !pulse_r && !fld.freeze) begin
                  if (pos == LAST) begin
                     state        <= SCORE;
                     point_q      <= 1'b1;
                     point_left_q <= 1'b1;
                  end else begin
                     pos <= pos + 1'b1;
                  end
               end else if (pulse_r && !pulse_l && !fld.freeze) begin
                  if (pos == '0) begin
                     state        <= SCORE;
                     point_q      <= 1'b1;
                     point_left_q <= 1'b0;
                  end else begin
                     pos <= pos - 1'b1;
                  end
               end
            end
            SCORE: begin
               state <= PLAY;
               pos   <= CENTER;
            end
            default: begin
               state <= PLAY;
               pos   <= CENTER;
            end
         endcase
      end
   end

   assign fld.L          = pulse_l;
   assign fld.R          = pulse_r;
   assign fld.point      = point_q;
   assign fld.pointLeft  = point_left_q;
   assign fld.leftLight  = (state == PLAY) && (pos == LAST);
   assign fld.rightLight = (state == PLAY) && (pos == '0);
   assign fld.lights     = (state == PLAY) ? (NUM_LIGHTS'(1) << pos) : '0;

endmodule
